// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - 5x5 sliding-window generator over a raster pixel stream
// Four line buffers feed a one-deep output stage that holds each window until win_ready.
module conv_window_gen #(
  parameter int DATA_W = 9,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic [DATA_W-1:0]     pix_data,
  output logic                  pix_ready,
  input  logic                  win_ready,
  output logic                  x_valid,
  output logic [5*DATA_W-1:0]   x_m_1,
  output logic [5*DATA_W-1:0]   x_m_2,
  output logic [5*DATA_W-1:0]   x_m_3,
  output logic [5*DATA_W-1:0]   x_m_4,
  output logic [5*DATA_W-1:0]   x_m_5,
  output logic                  frame_done
);

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int ROW_W = 5 * DATA_W;

  logic [CW-1:0]     col_q, col_d, col_eff;
  logic [RW-1:0]     row_q, row_d, row_eff;
  logic              x_valid_q, x_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [ROW_W-1:0]  m1_q, m2_q, m3_q, m4_q, m5_q;
  logic [ROW_W-1:0]  m1_d, m2_d, m3_d, m4_d, m5_d;
  logic              accept, col_last, row_last;

  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] lb2_q [IMG_W];
  logic [DATA_W-1:0] lb3_q [IMG_W];

  assign pix_ready = rstn && (!x_valid_q || win_ready);
  assign accept    = pix_valid && pix_ready;

  // A start-of-frame pixel overrides whatever position the counters held.
  assign col_eff  = pix_sof ? '0 : col_q;
  assign row_eff  = pix_sof ? '0 : row_q;
  assign col_last = (col_eff == CW'(IMG_W - 1));
  assign row_last = (row_eff == RW'(IMG_H - 1));

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    m1_d         = m1_q;
    m2_d         = m2_q;
    m3_d         = m3_q;
    m4_d         = m4_q;
    m5_d         = m5_q;
    x_valid_d    = x_valid_q;
    frame_done_d = 1'b0;
    if (accept) begin
      m1_d = {m1_q[ROW_W-DATA_W-1:0], lb3_q[col_eff]};
      m2_d = {m2_q[ROW_W-DATA_W-1:0], lb2_q[col_eff]};
      m3_d = {m3_q[ROW_W-DATA_W-1:0], lb1_q[col_eff]};
      m4_d = {m4_q[ROW_W-DATA_W-1:0], lb0_q[col_eff]};
      m5_d = {m5_q[ROW_W-DATA_W-1:0], pix_data};
      col_d = col_last ? '0 : col_eff + 1'b1;
      if (col_last) begin
        row_d = row_last ? '0 : row_eff + 1'b1;
      end else begin
        row_d = row_eff;
      end
      frame_done_d = col_last && row_last;
    end
    // The col/row gate keeps windows from straddling a line wrap.
    if (accept && (row_eff >= RW'(4)) && (col_eff >= CW'(4))) begin
      x_valid_d = 1'b1;
    end else if (win_ready) begin
      x_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q        <= '0;
      row_q        <= '0;
      x_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      m1_q         <= '0;
      m2_q         <= '0;
      m3_q         <= '0;
      m4_q         <= '0;
      m5_q         <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      x_valid_q    <= x_valid_d;
      frame_done_q <= frame_done_d;
      m1_q         <= m1_d;
      m2_q         <= m2_d;
      m3_q         <= m3_d;
      m4_q         <= m4_d;
      m5_q         <= m5_d;
    end
  end

  // Line storage is never exposed before being rewritten, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb3_q[col_eff] <= lb2_q[col_eff];
      lb2_q[col_eff] <= lb1_q[col_eff];
      lb1_q[col_eff] <= lb0_q[col_eff];
      lb0_q[col_eff] <= pix_data;
    end
  end

  assign x_valid    = x_valid_q;
  assign frame_done = frame_done_q;
  assign x_m_1      = m1_q;
  assign x_m_2      = m2_q;
  assign x_m_3      = m3_q;
  assign x_m_4      = m4_q;
  assign x_m_5      = m5_q;

endmodule
